// File: rtl/sfp_norm_pkg.sv
// Shared constants for the psum datapath (core, ofifo, sfp) so that lane widths
// and the row-sum width agree across blocks.
package sfp_norm_pkg;

    localparam int BW      = 4;           // activation / weight width
    localparam int BW_PSUM = 2 * BW + 3;  // psum lane width
    localparam int COL     = 8;           // lanes per row
    localparam int FRAC    = 8;           // fraction bits of normalized output

    // Lane i of a packed row lives at [bw_psum*(i+1)-1 : bw_psum*i].
    function automatic int sum_width(input int bw_psum, input int col);
        return bw_psum + $clog2(col);
    endfunction

    localparam int SUM_W = sum_width(BW_PSUM, COL);

endpackage

// File: rtl/sfp_udiv.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, MSB first.
// The start cycle already computes the first bit; done flags the final bit's cycle.
module sfp_udiv #(
    parameter int dw = 19,  // dividend width
    parameter int vw = 14,  // divisor width
    parameter int qw = 9    // quotient bits; caller guarantees quotient < 2^qw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [vw-1:0] divisor,
    output logic          done,
    output logic [qw-1:0] quotient
);

    localparam int CW = $clog2(qw + 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [vw-1:0] rem;
    logic [qw-1:0] bits;
    logic [qw-1:0] quo;

    logic [CW-1:0] src_cnt;
    logic [vw-1:0] src_rem;
    logic [qw-1:0] src_bits;
    logic [qw-1:0] src_quo;
    logic [vw:0]   cur;
    logic          ge;
    logic [vw-1:0] new_rem;
    logic          step;

    // The high dividend bits seed the remainder; they are below the divisor
    // because the quotient fits in qw bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        src_cnt  = cnt;
        src_rem  = rem;
        src_bits = bits;
        src_quo  = quo;
        if (start) begin
            src_cnt  = CW'(qw);
            src_rem  = vw'(dividend >> qw);
            src_bits = dividend[qw-1:0];
            src_quo  = '0;
        end
        step     = start | active;
        cur      = {src_rem, src_bits[qw-1]};
        ge       = cur >= {1'b0, divisor};
        new_rem  = ge ? vw'(cur - {1'b0, divisor}) : cur[vw-1:0];
        quotient = (src_quo << 1) | qw'(ge);
        done     = step && (src_cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            bits   <= '0;
            quo    <= '0;
        end else if (step) begin
            active <= (src_cnt != CW'(1));
            cnt    <= src_cnt - CW'(1);
            rem    <= new_rem;
            bits   <= src_bits << 1;
            quo    <= quotient;
        end
    end

endmodule

// File: rtl/sfp_norm.sv
// Row normalizer: out_i = sign(x_i) * floor(|x_i| * 2^frac / sum|x_j|), with one
// shared serial divider walking the lanes in order.
module sfp_norm
    import sfp_norm_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int frac    = FRAC
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [col*bw_psum-1:0]              in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [col*bw_psum-1:0]              out,
    output logic [sum_width(bw_psum, col)-1:0]  sum_out,
    output logic                                busy
);

    localparam int SW  = sum_width(bw_psum, col);
    localparam int DW  = bw_psum + frac;
    localparam int QW  = frac + 1;
    localparam int LW  = $clog2(col);
    localparam int BCW = $clog2(frac + 1);

    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

    state_t                 state;
    logic [col*bw_psum-1:0] row;
    logic [LW-1:0]          lane;
    logic [BCW-1:0]         bit_cnt;

    logic [bw_psum-1:0] mag [col];
    logic [SW-1:0]      sum_comb;
    logic [bw_psum-1:0] x_cur;
    logic [bw_psum-1:0] mag_cur;
    logic [bw_psum-1:0] q_ext;
    logic [bw_psum-1:0] lane_val;
    logic               div_start;
    logic               div_done;
    logic [QW-1:0]      div_q;

    // Magnitudes are unsigned bw_psum bits, so |-2^(bw_psum-1)| stays exact.
    always_comb begin
        sum_comb = '0;
        for (int i = 0; i < col; i++) begin
            mag[i]   = row[i*bw_psum +: bw_psum];
            mag[i]   = mag[i][bw_psum-1] ? -mag[i] : mag[i];
            sum_comb = sum_comb + SW'(mag[i]);
        end
        x_cur    = row[lane*bw_psum +: bw_psum];
        mag_cur  = x_cur[bw_psum-1] ? -x_cur : x_cur;
        q_ext    = bw_psum'(div_q);
        lane_val = x_cur[bw_psum-1] ? -q_ext : q_ext;
    end

    assign div_start = (state == DIV) && (bit_cnt == '0);

    sfp_udiv #(
        .dw (DW),
        .vw (SW),
        .qw (QW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend ({mag_cur, {frac{1'b0}}}),
        .divisor  (sum_out),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: row and result registers are reset so an aborted row leaves nothing behind.
            state     <= IDLE;
            row       <= '0;
            out       <= '0;
            sum_out   <= '0;
            lane      <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    row      <= in;
                    state    <= SUM;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                SUM: begin
                    sum_out <= sum_comb;
                    lane    <= '0;
                    bit_cnt <= '0;
                    if (sum_comb == '0) begin
                        out       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    bit_cnt <= (bit_cnt == BCW'(frac)) ? '0 : bit_cnt + BCW'(1);
                    if (div_done) begin
                        out[lane*bw_psum +: bw_psum] <= lane_val;
                        if (lane == LW'(col - 1)) begin
                            lane      <= '0;
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_norm.sv
// Bench for sfp_norm: fixed vectors, backpressure and mid-row reset sequences,
// then random rows against an arithmetic reference model.
module tb_sfp_norm;
    import sfp_norm_pkg::*;

    localparam int W  = BW_PSUM;
    localparam int RW = COL * BW_PSUM;
    localparam int LAT_FULL = 1 + COL * (FRAC + 1);

    typedef int row_t [COL];
    typedef struct {
        row_t x;
        int   sum;
        row_t y;
        int   lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic [SUM_W-1:0] sum_out;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sfp_norm #(
        .col     (COL),
        .bw_psum (BW_PSUM),
        .frac    (FRAC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_row),
        .sum_out   (sum_out),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack(input row_t x);
        logic [RW-1:0] p;
        for (int i = 0; i < COL; i++) p[i*W +: W] = W'(x[i]);
        return p;
    endfunction

    function automatic int lane_of(input logic [RW-1:0] v, input int i);
        logic signed [W-1:0] l;
        l = v[i*W +: W];
        return int'(l);
    endfunction

    // Reference: plain integer arithmetic straight from the normalization rule.
    function automatic void model(input row_t x, output int s, output row_t y);
        s = 0;
        for (int i = 0; i < COL; i++) s += (x[i] < 0) ? -x[i] : x[i];
        for (int i = 0; i < COL; i++) begin
            int a;
            int q;
            a = (x[i] < 0) ? -x[i] : x[i];
            q = (s == 0) ? 0 : (a * (1 << FRAC)) / s;
            y[i] = (x[i] < 0) ? -q : q;
        end
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic run_row(input row_t x, output int lat, output logic [RW-1:0] o, output int s);
        check("accept_in_ready", int'(in_ready), 1);
        in_row   = pack(x);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        o = out_row;
        s = int'(sum_out);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_out_valid", int'(out_valid), 0);
    endtask

    task automatic check_row(input string tag, input logic [RW-1:0] o, input int s, input int lat,
                             input row_t ey, input int es, input int elat);
        check($sformatf("%s_sum", tag), s, es);
        check($sformatf("%s_lat", tag), lat, elat);
        for (int i = 0; i < COL; i++)
            check($sformatf("%s_lane%0d", tag, i), lane_of(o, i), ey[i]);
    endtask

    initial begin
        vec_t vecs[7];
        logic [RW-1:0] o;
        logic [RW-1:0] ref_out;
        int s, lat, ref_sum;
        row_t x, ey;
        int es;

        vecs[0] = '{x: '{5, 5, 5, 5, 5, 5, 5, 5}, sum: 40,
                    y: '{32, 32, 32, 32, 32, 32, 32, 32}, lat: LAT_FULL};
        vecs[1] = '{x: '{100, -100, 1, 2, 0, 0, 0, 0}, sum: 203,
                    y: '{126, -126, 1, 2, 0, 0, 0, 0}, lat: LAT_FULL};
        vecs[2] = '{x: '{1, 2, 0, 0, 0, 0, 0, 0}, sum: 3,
                    y: '{85, 170, 0, 0, 0, 0, 0, 0}, lat: LAT_FULL};
        vecs[3] = '{x: '{-1024, 0, 0, 0, 0, 0, 0, 0}, sum: 1024,
                    y: '{-256, 0, 0, 0, 0, 0, 0, 0}, lat: LAT_FULL};
        vecs[4] = '{x: '{0, 0, 0, 0, 0, 0, 0, 0}, sum: 0,
                    y: '{0, 0, 0, 0, 0, 0, 0, 0}, lat: 1};
        vecs[5] = '{x: '{1023, 1, 0, 0, 0, 0, 0, 0}, sum: 1024,
                    y: '{255, 0, 0, 0, 0, 0, 0, 0}, lat: LAT_FULL};
        vecs[6] = '{x: '{0, 0, 0, 0, 0, 0, 0, -1}, sum: 1,
                    y: '{0, 0, 0, 0, 0, 0, 0, -256}, lat: LAT_FULL};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check_vec("rst_out", 128'(out_row), 128'(0));
        check("rst_sum", int'(sum_out), 0);

        for (int v = 0; v < 7; v++) begin
            run_row(vecs[v].x, lat, o, s);
            check_row($sformatf("vec%0d", v), o, s, lat, vecs[v].y, vecs[v].sum, vecs[v].lat);
            handshake();
        end

        // Backpressure: result held while a new row waits on in_valid.
        run_row(vecs[0].x, lat, ref_out, ref_sum);
        in_row   = pack(vecs[2].x);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_vec("bp_out_stable", 128'(out_row), 128'(ref_out));
            check("bp_sum_stable", int'(sum_out), 40);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        handshake();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted_busy", int'(busy), 1);
        check("bp_accepted_in_ready", int'(in_ready), 0);
        wait_out(lat);
        check_row("bp_next", out_row, int'(sum_out), lat, vecs[2].y, vecs[2].sum, LAT_FULL);
        handshake();

        // Reset while the divider is working on lane 3.
        run_row_start: begin
            in_row   = pack(vecs[1].x);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        repeat (31) @(posedge clk);
        #1;
        check("mid_busy_before_reset", int'(busy), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check_vec("mid_rst_out", 128'(out_row), 128'(0));
        check("mid_rst_sum", int'(sum_out), 0);
        run_row(vecs[0].x, lat, o, s);
        check_row("after_rst", o, s, lat, vecs[0].y, vecs[0].sum, LAT_FULL);
        handshake();

        // Random rows against the reference model, with random consumer delay.
        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            for (int i = 0; i < COL; i++) begin
                case (mode)
                    0: x[i] = int'($urandom_range(0, 2047)) - 1024;
                    1: x[i] = int'($urandom_range(0, 16)) - 8;
                    2: x[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2047)) - 1024 : 0;
                    default: x[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
                endcase
            end
            model(x, es, ey);
            run_row(x, lat, o, s);
            check_row($sformatf("rnd%0d", r), o, s, lat, ey, es, (es == 0) ? 1 : LAT_FULL);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            check_vec("rnd_hold", 128'(out_row), 128'(o));
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
